alu_risc_seq: RTL and testbench

Registered, handshaked, width-parametrised ALU for the RISC datapath. It executes the processor's 8-bit opcode set on two operands. Single-cycle operations complete one cycle after acceptance. MOD runs on an iterative restoring divider. The block sits between the register-file read stage and write-back, and presents a registered result with a status-flag vector.

---
 rtl/alu_risc_seq_if.sv | 31 +++
 rtl/alu_risc_seq.sv | 203 ++++++++++++++++++++
 tb/tb_alu_risc_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_risc_seq_if.sv
// alu_risc_seq_if: handshake bundle between the register-file read stage,
// the ALU and write-back.
//   in_valid/in_ready        operand/opcode handshake (producer -> ALU)
//   sel, data_1, data_2      opcode, operand A, operand B
//   out_valid/out_ready      result handshake (ALU -> consumer)
//   alu_out, alu_flags       registered result, {illegal,div0,ovf,neg,carry,zero}
// Modports: master = producer/consumer side, slave = ALU side.
interface alu_risc_seq_if #(
  parameter int WORD_SIZE = 8,
  parameter int OP_SIZE   = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [OP_SIZE-1:0]   sel;
  logic [WORD_SIZE-1:0] data_1;
  logic [WORD_SIZE-1:0] data_2;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] alu_out;
  logic [5:0]           alu_flags;

  modport master (
    output in_valid, sel, data_1, data_2, out_ready,
    input  in_ready, out_valid, alu_out, alu_flags
  );

  modport slave (
    input  in_valid, sel, data_1, data_2, out_ready,
    output in_ready, out_valid, alu_out, alu_flags
  );
endinterface

// File: rtl/alu_risc_seq.sv
// alu_risc_seq: registered, handshaked ALU for the RISC datapath.
// Single-cycle ops produce a result one cycle after acceptance; MOD uses an
// iterative restoring divider (WORD_SIZE cycles) when ALU_RISC_MOD_EN is
// defined, otherwise MOD is decoded as an illegal opcode.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-low
//   bus   alu_risc_seq_if.slave: in_valid/in_ready, sel, data_1 (A),
//         data_2 (B), out_valid/out_ready, alu_out, alu_flags
//         alu_flags = {illegal, div0, ovf, neg, carry, zero}
// Optional feature macro: ALU_RISC_MOD_EN
module alu_risc_seq #(
  parameter int WORD_SIZE = 8,
  parameter int OP_SIZE   = 8
) (
  input logic         clk,
  input logic         rst,
  alu_risc_seq_if.slave bus
);
  localparam int W = WORD_SIZE;

  localparam logic [OP_SIZE-1:0] OP_NOP   = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] OP_ADD   = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] OP_ADDI  = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] OP_SUB   = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_INC   = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] OP_DEC   = OP_SIZE'(5);
  localparam logic [OP_SIZE-1:0] OP_MOVE  = OP_SIZE'(7);
  localparam logic [OP_SIZE-1:0] OP_SLT   = OP_SIZE'(9);
  localparam logic [OP_SIZE-1:0] OP_SGT   = OP_SIZE'(10);
  localparam logic [OP_SIZE-1:0] OP_AND   = OP_SIZE'(11);
  localparam logic [OP_SIZE-1:0] OP_ANDI  = OP_SIZE'(12);
  localparam logic [OP_SIZE-1:0] OP_OR    = OP_SIZE'(13);
  localparam logic [OP_SIZE-1:0] OP_ORI   = OP_SIZE'(14);
  localparam logic [OP_SIZE-1:0] OP_NAND  = OP_SIZE'(15);
  localparam logic [OP_SIZE-1:0] OP_NANDI = OP_SIZE'(16);
  localparam logic [OP_SIZE-1:0] OP_NOR   = OP_SIZE'(17);
  localparam logic [OP_SIZE-1:0] OP_NORI  = OP_SIZE'(18);
  localparam logic [OP_SIZE-1:0] OP_XOR   = OP_SIZE'(19);
  localparam logic [OP_SIZE-1:0] OP_XORI  = OP_SIZE'(20);
  localparam logic [OP_SIZE-1:0] OP_LDR   = OP_SIZE'(23);
  localparam logic [OP_SIZE-1:0] OP_STR   = OP_SIZE'(25);
  localparam logic [OP_SIZE-1:0] OP_SKIP  = OP_SIZE'(30);
`ifdef ALU_RISC_MOD_EN
  localparam logic [OP_SIZE-1:0] OP_MOD   = OP_SIZE'(6);
`endif

  logic [W-1:0] a, b, res;
  logic [W:0]   sum;
  logic         f_ill, f_div0, f_ovf, f_carry;
  logic         mod_start;
  logic         accept, load;
  logic         in_ready;
  logic [W-1:0] out_q, load_out;
  logic [5:0]   flags_q, load_flags;
  logic         valid_q;

  assign a = bus.data_1;
  assign b = bus.data_2;

  // Single-cycle datapath; mod_start flags a MOD that needs the divider.
  always_comb begin
    res       = '0;
    sum       = '0;
    f_ill     = 1'b0;
    f_div0    = 1'b0;
    f_ovf     = 1'b0;
    f_carry   = 1'b0;
    mod_start = 1'b0;
    case (bus.sel)
      OP_NOP: res = '0;
      OP_ADD, OP_ADDI: begin
        sum     = {1'b0, a} + {1'b0, b};
        res     = sum[W-1:0];
        f_carry = sum[W];
        f_ovf   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res     = b - a;
        f_carry = b < a;
        f_ovf   = (b[W-1] != a[W-1]) && (res[W-1] != b[W-1]);
      end
      OP_INC, OP_LDR, OP_STR: begin
        sum     = {1'b0, b} + {{W{1'b0}}, 1'b1};
        res     = sum[W-1:0];
        f_carry = sum[W];
        f_ovf   = !b[W-1] && res[W-1];
      end
      OP_DEC: begin
        res     = b - 1'b1;
        f_carry = b == '0;
        f_ovf   = b[W-1] && !res[W-1];
      end
`ifdef ALU_RISC_MOD_EN
      OP_MOD: begin
        if (a == '0) begin
          res    = b;
          f_div0 = 1'b1;
        end else begin
          mod_start = 1'b1;
        end
      end
`endif
      OP_MOVE:           res = a;
      OP_SLT:            res = W'(b < a);
      OP_SGT:            res = W'(b > a);
      OP_AND, OP_ANDI:   res = a & b;
      OP_OR, OP_ORI:     res = a | b;
      OP_NAND, OP_NANDI: res = ~(a & b);
      OP_NOR, OP_NORI:   res = ~(a | b);
      OP_XOR, OP_XORI:   res = a ^ b;
      OP_SKIP:           res = W'(a == b);
      default:           f_ill = 1'b1;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

`ifdef ALU_RISC_MOD_EN
  localparam int CNT_W = $clog2(WORD_SIZE + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     div_q, div_d, div_rem, step_rem;
  logic [W:0]       shifted, trial;
  logic             div_done;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted  = {div_rem, div_q[W-1]};
    trial    = shifted - {1'b0, div_d};
    step_rem = trial[W] ? shifted[W-1:0] : trial[W-1:0];
  end

  always_comb begin
    state_nxt = state;
    div_done  = 1'b0;
    case (state)
      S_IDLE: if (accept && mod_start) state_nxt = S_BUSY;
      S_BUSY: if (cnt == CNT_W'(1)) begin
        div_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      div_q   <= '0;
      div_d   <= '0;
      div_rem <= '0;
    end else if (accept && mod_start) begin
      cnt     <= CNT_W'(WORD_SIZE);
      div_q   <= b;
      div_d   <= a;
      div_rem <= '0;
    end else if (state == S_BUSY) begin
      cnt     <= cnt - 1'b1;
      div_q   <= {div_q[W-2:0], 1'b0};
      div_rem <= step_rem;
    end
  end

  assign in_ready   = (state == S_IDLE) && (!valid_q || bus.out_ready);
  assign load       = (accept && !mod_start) || div_done;
  assign load_out   = div_done ? step_rem : res;
  assign load_flags = div_done ? {3'b000, step_rem[W-1], 1'b0, step_rem == '0}
                               : {f_ill, f_div0, f_ovf, res[W-1], f_carry, res == '0};
`else
  assign in_ready   = !valid_q || bus.out_ready;
  assign load       = accept;
  assign load_out   = res;
  assign load_flags = {f_ill, f_div0, f_ovf, res[W-1], f_carry, res == '0};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      flags_q <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      out_q   <= load_out;
      flags_q <= load_flags;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.alu_out   = out_q;
  assign bus.alu_flags = flags_q;
endmodule

// File: tb/tb_alu_risc_seq.sv
module tb_alu_risc_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  alu_risc_seq_if #(.WORD_SIZE(8), .OP_SIZE(8)) bus ();

  alu_risc_seq #(.WORD_SIZE(8), .OP_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [5:0] flags;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one accept edge, then sample 1 after it.
  task automatic issue(input logic [7:0] sel, input logic [7:0] a, input logic [7:0] b);
    bus.sel      = sel;
    bus.data_1   = a;
    bus.data_2   = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] res, input logic [5:0] flags);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_out"},   32'(bus.alu_out),   32'(res));
    check({tag, "_flags"}, 32'(bus.alu_flags), 32'(flags));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.sel       = '0;
    bus.data_1    = '0;
    bus.data_2    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out",   32'(bus.alu_out),   32'd0);
    check("rst_flags", 32'(bus.alu_flags), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Add flags
    issue(8'd1, 8'hFF, 8'h01);
    check_result("add_ff", 8'h00, 6'b000011);
    issue(8'd1, 8'h7F, 8'h01);
    check_result("add_7f", 8'h80, 6'b001100);
    tick();

    // Back-to-back stream
    bus.sel = 8'd3; bus.data_1 = 8'd5; bus.data_2 = 8'd3; bus.in_valid = 1'b1;
    check("b2b_ready0", 32'(bus.in_ready), 32'd1);
    tick();
    check_result("b2b_sub", 8'hFE, 6'b000110);
    bus.sel = 8'd19; bus.data_1 = 8'hF0; bus.data_2 = 8'h3C;
    check("b2b_ready1", 32'(bus.in_ready), 32'd1);
    tick();
    check_result("b2b_xor", 8'hCC, 6'b000100);
    bus.in_valid = 1'b0;
    tick();
    check("b2b_drain", 32'(bus.out_valid), 32'd0);

    // Opcode table
    vecs.push_back('{8'd0,  8'h12, 8'h34, 8'h00, 6'b000001});
    vecs.push_back('{8'd2,  8'h03, 8'h04, 8'h07, 6'b000000});
    vecs.push_back('{8'd3,  8'h03, 8'h05, 8'h02, 6'b000000});
    vecs.push_back('{8'd3,  8'h01, 8'h80, 8'h7F, 6'b001000});
    vecs.push_back('{8'd4,  8'h00, 8'hFF, 8'h00, 6'b000011});
    vecs.push_back('{8'd4,  8'h00, 8'h7F, 8'h80, 6'b001100});
    vecs.push_back('{8'd23, 8'h00, 8'h05, 8'h06, 6'b000000});
    vecs.push_back('{8'd25, 8'h00, 8'h10, 8'h11, 6'b000000});
    vecs.push_back('{8'd5,  8'h00, 8'h00, 8'hFF, 6'b000110});
    vecs.push_back('{8'd5,  8'h00, 8'h80, 8'h7F, 6'b001000});
    vecs.push_back('{8'd7,  8'h9A, 8'h11, 8'h9A, 6'b000100});
    vecs.push_back('{8'd9,  8'h05, 8'h03, 8'h01, 6'b000000});
    vecs.push_back('{8'd9,  8'h03, 8'h05, 8'h00, 6'b000001});
    vecs.push_back('{8'd10, 8'h03, 8'h05, 8'h01, 6'b000000});
    vecs.push_back('{8'd11, 8'hF0, 8'h3C, 8'h30, 6'b000000});
    vecs.push_back('{8'd12, 8'hF0, 8'h3C, 8'h30, 6'b000000});
    vecs.push_back('{8'd13, 8'hF0, 8'h3C, 8'hFC, 6'b000100});
    vecs.push_back('{8'd14, 8'hF0, 8'h3C, 8'hFC, 6'b000100});
    vecs.push_back('{8'd15, 8'hF0, 8'h3C, 8'hCF, 6'b000100});
    vecs.push_back('{8'd16, 8'hF0, 8'h3C, 8'hCF, 6'b000100});
    vecs.push_back('{8'd17, 8'hF0, 8'h3C, 8'h03, 6'b000000});
    vecs.push_back('{8'd18, 8'hF0, 8'h3C, 8'h03, 6'b000000});
    vecs.push_back('{8'd20, 8'h55, 8'h55, 8'h00, 6'b000001});
    vecs.push_back('{8'd30, 8'h05, 8'h05, 8'h01, 6'b000000});
    vecs.push_back('{8'd30, 8'h05, 8'h06, 8'h00, 6'b000001});
    vecs.push_back('{8'd8,  8'h05, 8'h06, 8'h00, 6'b100001});
    vecs.push_back('{8'd21, 8'h05, 8'h06, 8'h00, 6'b100001});
    vecs.push_back('{8'd31, 8'h05, 8'h06, 8'h00, 6'b100001});
    foreach (vecs[i]) begin
      issue(vecs[i].sel, vecs[i].a, vecs[i].b);
      check_result($sformatf("vec%0d_op%0d", i, vecs[i].sel), vecs[i].res, vecs[i].flags);
    end
    tick();

`ifdef ALU_RISC_MOD_EN
    // Remainder 200 % 7 = 4, exactly 8 cycles after accept
    issue(8'd6, 8'd7, 8'd200);
    check("mod_ready_busy0", 32'(bus.in_ready), 32'd0);
    for (int i = 1; i < 8; i++) begin
      bus.data_1 = 8'hAA; // changes during BUSY must be ignored
      tick();
      check($sformatf("mod_wait%0d_valid", i), 32'(bus.out_valid), 32'd0);
      check($sformatf("mod_wait%0d_ready", i), 32'(bus.in_ready), 32'd0);
    end
    tick();
    check_result("mod_200_7", 8'd4, 6'b000000);
    tick();
    // B < A leaves B as remainder
    issue(8'd6, 8'd200, 8'd7);
    for (int i = 1; i < 8; i++) tick();
    tick();
    check_result("mod_7_200", 8'd7, 6'b000000);
    tick();
    // Divide by zero, single-cycle
    issue(8'd6, 8'd0, 8'd9);
    check_result("mod_div0", 8'd9, 6'b010000);
    tick();
`else
    issue(8'd6, 8'd7, 8'd200);
    check_result("mod_illegal", 8'd0, 6'b100001);
    tick();
`endif

    // Illegal opcode and backpressure
    bus.out_ready = 1'b0;
    issue(8'hFF, 8'h12, 8'h34);
    check_result("ill_ff", 8'h00, 6'b100001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_result($sformatf("bp%0d", i), 8'h00, 6'b100001);
      check($sformatf("bp%0d_ready", i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_drain", 32'(bus.out_valid), 32'd0);

    // Reset mid-MOD
    issue(8'd6, 8'd7, 8'd200);
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rmod_valid", 32'(bus.out_valid), 32'd0);
    check("rmod_out",   32'(bus.alu_out),   32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("rmod_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("rmod_idle_valid", 32'(bus.out_valid), 32'd0);
    issue(8'd1, 8'd1, 8'd1);
    check_result("rmod_add", 8'd2, 6'b000000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
